// File: rtl/rsa_modexp_ctrl_pkg.sv
// rtl/rsa_modexp_ctrl_pkg.sv - shared types and constants for the modexp sequencer
// Purpose: FSM state encoding, modmul handshake timing constants and a
//          width helper for the exponent bit counter.
// Ports:   none (package)
package rsa_modexp_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REDUCE = 3'd1,
      ST_SQUARE = 3'd2,
      ST_MULT   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Earliest cycle (counted in req-high cycles) at which mm_ack may arrive.
   localparam int MM_MIN_LATENCY  = 1;
   // Cycles spent in each operation state before mm_req is raised.
   localparam int MM_ISSUE_CYCLES = 1;

   // Bit index counter width; a single exponent bit still needs one flop.
   function automatic int cntr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rsa_modexp_ctrl_if.sv
// rtl/rsa_modexp_ctrl_if.sv - req/ack bus to the shared modular multiplier
// Purpose: bundles the modmul handshake so the sequencer and the multiplier
//          (or a bench model) connect through one port.
// Ports:   req  sequencer -> modmul, held until ack
//          a, b operands, stable while req
//          n    modulus (latched N)
//          ack  modmul -> sequencer, 1-cycle pulse
//          res  (a*b) mod n, valid in the ack cycle
interface rsa_modexp_ctrl_if #(parameter int N_width = 4);

   logic               req;
   logic               ack;
   logic [N_width-1:0] a;
   logic [N_width-1:0] b;
   logic [N_width-1:0] n;
   logic [N_width-1:0] res;

   modport master (output req, a, b, n, input ack, res);
   modport slave  (input req, a, b, n, output ack, res);

endinterface

// File: rtl/rsa_modexp_ctrl_expo_bit_cntr.sv
// rtl/rsa_modexp_ctrl_expo_bit_cntr.sv - exponent bit index down-counter
// Purpose: holds the bit index k walked from the MSB down to bit 0.
// Ports:   clk, rst (async active-low)
//          load   k <= load_val
//          dec    k <= k - 1
//          k      current bit index
//          k_zero k == 0 (last exponent bit)
module expo_bit_cntr #(
   parameter int          kw       = 2,
   parameter int unsigned load_val = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   output logic [kw-1:0] k,
   output logic          k_zero
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         k <= '0;
      else if (load)
         k <= kw'(load_val);
      else if (dec)
         k <= k - kw'(1);
   end

   assign k_zero = (k == '0);

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// rtl/rsa_modexp_ctrl.sv - square-and-multiply sequencer for base^expo mod N
// Purpose: left-to-right binary modular exponentiation driving one shared
//          modmul unit; the controller itself does no arithmetic.
// Ports:   clk, rst (async active-low)
//          start  1-cycle pulse, accepted only when idle
//          base, expo, N  operands, sampled on accepted start
//          busy   high from the cycle after start until valid rises
//          valid  result final, held until the next accepted start
//          result final value, 0 while valid is low
//          mm     modmul bus (master side)
module rsa_modexp_ctrl
   import rsa_modexp_ctrl_pkg::*;
#(
   parameter int base_width = 4,
   parameter int expo_width = 4,
   parameter int N_width    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [base_width-1:0] base,
   input  logic [expo_width-1:0] expo,
   input  logic [N_width-1:0]    N,
   output logic                  busy,
   output logic                  valid,
   output logic [N_width-1:0]    result,
   rsa_modexp_ctrl_if.master     mm
);

   localparam int kw = cntr_width(expo_width);

   state_t                state, state_next;
   logic [base_width-1:0] base_r;
   logic [expo_width-1:0] expo_r;
   logic [N_width-1:0]    n_r, acc, b_r, a_op, b_op, result_r;
   logic                  req_r, busy_r, valid_r;
   logic                  accept, issue, capture, cnt_dec, k_zero;
   logic [kw-1:0]         k;

   expo_bit_cntr #(.kw(kw), .load_val(expo_width - 1)) u_cntr (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .dec   (cnt_dec),
      .k     (k),
      .k_zero(k_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Each operation state spends one cycle raising req, then waits for ack.
   // The ack cycle only captures; the next request is issued from the
   // following state, so req always has a low cycle between operations.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      issue      = 1'b0;
      capture    = 1'b0;
      cnt_dec    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (N < N_width'(2) || expo == '0)
                  state_next = ST_DONE;
               else
                  state_next = ST_REDUCE;
            end
         end
         ST_REDUCE, ST_SQUARE, ST_MULT: begin
            if (!req_r)
               issue = 1'b1;
            else if (mm.ack) begin
               capture = 1'b1;
               if (state == ST_REDUCE)
                  state_next = ST_SQUARE;
               else if (state == ST_SQUARE && expo_r[k])
                  state_next = ST_MULT;
               else if (k_zero)
                  state_next = ST_DONE;
               else begin
                  cnt_dec    = 1'b1;
                  state_next = ST_SQUARE;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_r   <= '0;
         expo_r   <= '0;
         n_r      <= '0;
         acc      <= '0;
         b_r      <= '0;
         a_op     <= '0;
         b_op     <= '0;
         result_r <= '0;
         req_r    <= 1'b0;
         busy_r   <= 1'b0;
         valid_r  <= 1'b0;
      end else begin
         if (accept) begin
            base_r   <= base;
            expo_r   <= expo;
            n_r      <= N;
            valid_r  <= 1'b0;
            busy_r   <= 1'b1;
            result_r <= '0;
            // A degenerate modulus forces result 0 without touching modmul.
            acc      <= (N < N_width'(2)) ? '0 : N_width'(1);
         end
         if (issue) begin
            req_r <= 1'b1;
            case (state)
               ST_REDUCE: begin a_op <= N_width'(base_r); b_op <= N_width'(1); end
               ST_SQUARE: begin a_op <= acc;              b_op <= acc;         end
               default:   begin a_op <= acc;              b_op <= b_r;         end
            endcase
         end
         if (capture) begin
            req_r <= 1'b0;
            if (state == ST_REDUCE)
               b_r <= mm.res;
            else
               acc <= mm.res;
         end
         if (state == ST_DONE) begin
            result_r <= acc;
            valid_r  <= 1'b1;
            busy_r   <= 1'b0;
         end
      end
   end

   assign busy   = busy_r;
   assign valid  = valid_r;
   assign result = result_r;
   assign mm.req = req_r;
   assign mm.a   = a_op;
   assign mm.b   = b_op;
   assign mm.n   = n_r;

endmodule
